data_bus_initiator: RTL and testbench
=====================================

Name: data_bus_initiator

Overview:
Core-side initiator for the data memory bus (address/byte_enable/read_enable/write_enable with wait_req/valid handshake). Converts one load/store request per cycle into aligned word-bus transactions, handling byte-lane steering and store-data replication. Tracks outstanding reads in order, then extracts and sign/zero-extends returning data. Sits between the core's memory stage and the data memory bus.

Parameters:
MAX_PENDING, 4, max outstanding loads tracked (power of 2, >=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core presents request
req_ready  out  1  request accepted this cycle when req_valid && req_ready
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_address  in  32  byte address
req_store_data  in  32  store data, LSB-aligned
resp_valid  out  1  load result valid (1-cycle pulse)
resp_data  out  32  extended load result
misaligned  out  1  request rejected: misaligned or illegal funct3
bus_address  out  32  word address, bits [1:0] forced to 0
bus_write_data  out  32  lane-steered store data
bus_byte_enable  out  4  active lanes
bus_read_enable  out  1  read request
bus_write_enable  out  1  write request
bus_wait_req  in  1  responder cannot accept this cycle
bus_read_data  in  32  read word
bus_valid  in  1  read data valid (in-order)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Legality: load funct3 000/001/010/100/101; store funct3 000/001/010. Half requires addr[0]=0; word requires addr[1:0]=00. Otherwise illegal.
- Illegal request: misaligned=req_valid (combinational), req_ready=1, no bus enable asserted, no FIFO push.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Loads drive the same enables.
- Write data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Bus drive (combinational from request): bus_read_enable = req_valid && load && legal && !fifo_full; bus_write_enable = req_valid && store && legal.
- req_ready: legal load = !bus_wait_req && !fifo_full; legal store = !bus_wait_req.
- Accepted load pushes {funct3, addr[1:0]} into the pending FIFO. No push/pop bypass: full blocks pushes even if a pop occurs the same cycle.
- bus_valid with FIFO non-empty pops the head. On the next clock edge, resp_valid=1 and resp_data = extracted value: byte lane addr[1:0], half lane addr[1], sign-extended for 000/001, zero-extended for 100/101, word passthrough. Load latency = bus latency + 1 cycle.
- bus_valid with FIFO empty: ignored, no resp_valid.
- Simultaneous push and pop: both take effect; count unchanged.
- Count saturation/wrap: pointers are log2(MAX_PENDING) bits wrapping naturally; count is 0..MAX_PENDING.
- Reset values: resp_valid=0, resp_data=0, FIFO empty. Mid-operation reset discards pending loads; the responder shares the reset, so no stale responses arrive.
- Stores produce no response.

Optional Feature:
Macro DATA_BUS_INITIATOR_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores, stat_stall_cycles (32 bits each, reset 0, wrap at 2^32). These count accepted loads, accepted stores, and cycles with req_valid && !req_ready.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) go in the shared constants header as named constants.
- One sub-module, data_bus_pending_fifo: parameterised width/depth, synchronous push/pop, full/empty, async reset.
- Lane steering and extraction stay inline.

Test Plan:
1. SB addr 0x1003 data 0xA5 -> bus_byte_enable=1000, bus_write_data=0xA5A5A5A5, bus_address=0x1000, req_ready=1.
2. LB addr 0x1002, bus returns 0x00800000 -> resp_valid one cycle after bus_valid, resp_data=0xFFFFFF80; LBU same -> 0x00000080.
3. LH addr 0x1001 -> misaligned=1, req_ready=1, no bus enables, no response.
4. bus_wait_req=1 for 3 cycles during LW -> req_ready=0 for 3 cycles, bus_read_enable held; accepted on the 4th cycle.
5. Issue 5 back-to-back LW with MAX_PENDING=4 and bus latency 5 -> 5th stalls until the first bus_valid; 5 in-order responses.
6. Assert reset with 2 loads pending -> resp_valid=0, FIFO empty; a subsequent LW completes normally.

Source files
------------

// File: rtl/data_bus_initiator_pkg.sv
// Shared constants, pending-load entry type and load/store helpers for the data bus initiator.
// Configuration: DATA_BUS_INITIATOR_STATS_EN (see data_bus_initiator.sv) adds request statistics counters.
package data_bus_initiator_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
    } pend_entry_t;

    // Store encodings are a subset of the load encodings, so one table covers both.
    function automatic logic is_legal(input logic is_store, input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~lane[0];
            F3_LW:   ok = (lane == 2'b00);
            F3_LBU:  ok = ~is_store;
            F3_LHU:  ok = ~is_store & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] extract_load(input pend_entry_t e, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (e.lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = e.lane[1] ? word[31:16] : word[15:0];
        case (e.funct3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = word;
            F3_LBU:  r = {24'h000000, b};
            F3_LHU:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_bus_pending_fifo.sv
// In-order FIFO of outstanding load descriptors; synchronous push/pop, async active-high reset.
module data_bus_pending_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [0:(2**PTR_W)-1];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == CNT_W'(0));
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;
    assign pop_data = mem_r[rd_ptr_r];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**PTR_W; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_initiator.sv
// Core-side load/store initiator for the word-wide data memory bus with in-order load tracking.
// Define DATA_BUS_INITIATOR_STATS_EN to add stat_loads / stat_stores / stat_stall_cycles outputs.
module data_bus_initiator
    import data_bus_initiator_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        misaligned,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic        bus_wait_req,
    input  logic [31:0] bus_read_data,
    input  logic        bus_valid
`ifdef DATA_BUS_INITIATOR_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_stall_cycles
`endif
);

    logic        legal_s;
    logic [1:0]  lane_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        push_s;
    logic        pop_s;
    pend_entry_t push_entry_s;
    pend_entry_t head_s;
    logic        resp_valid_r;
    logic [31:0] resp_data_r;

    // Request decode, lane steering and bus/handshake drive.
    always_comb begin
        lane_s           = req_address[1:0];
        legal_s          = is_legal(req_is_store, req_funct3, lane_s);
        bus_address      = {req_address[31:2], 2'b00};
        bus_byte_enable  = 4'b0000;
        bus_write_data   = 32'h0000_0000;
        case (req_funct3[1:0])
            2'b00: begin
                bus_byte_enable = 4'b0001 << lane_s;
                bus_write_data  = {4{req_store_data[7:0]}};
            end
            2'b01: begin
                bus_byte_enable = 4'b0011 << {lane_s[1], 1'b0};
                bus_write_data  = {2{req_store_data[15:0]}};
            end
            2'b10: begin
                bus_byte_enable = 4'b1111;
                bus_write_data  = req_store_data;
            end
            default: begin
                bus_byte_enable = 4'b0000;
                bus_write_data  = 32'h0000_0000;
            end
        endcase
        bus_read_enable  = req_valid && !req_is_store && legal_s && !fifo_full_s;
        bus_write_enable = req_valid && req_is_store && legal_s;
        misaligned       = req_valid && !legal_s;
        // Illegal requests are consumed immediately so the core does not hang on them.
        if (!legal_s) begin
            req_ready = 1'b1;
        end else if (req_is_store) begin
            req_ready = !bus_wait_req;
        end else begin
            req_ready = !bus_wait_req && !fifo_full_s;
        end
        push_s              = req_valid && !req_is_store && legal_s && !bus_wait_req && !fifo_full_s;
        pop_s               = bus_valid && !fifo_empty_s;
        push_entry_s.funct3 = req_funct3;
        push_entry_s.lane   = lane_s;
    end

    data_bus_pending_fifo #(
        .WIDTH ($bits(pend_entry_t)),
        .DEPTH (MAX_PENDING)
    ) u_pending (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Load response register: one-cycle pulse holding the extended result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
        end else begin
            resp_valid_r <= pop_s;
            if (pop_s) begin
                resp_data_r <= extract_load(head_s, bus_read_data);
            end else begin
                resp_data_r <= resp_data_r;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;

`ifdef DATA_BUS_INITIATOR_STATS_EN
    logic [31:0] stat_loads_r;
    logic [31:0] stat_stores_r;
    logic [31:0] stat_stall_r;

    // Free-running statistics counters; wrap naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_loads_r  <= 32'h0000_0000;
            stat_stores_r <= 32'h0000_0000;
            stat_stall_r  <= 32'h0000_0000;
        end else begin
            if (push_s) begin
                stat_loads_r <= stat_loads_r + 32'd1;
            end
            if (bus_write_enable && !bus_wait_req) begin
                stat_stores_r <= stat_stores_r + 32'd1;
            end
            if (req_valid && !req_ready) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end
        end
    end

    assign stat_loads        = stat_loads_r;
    assign stat_stores       = stat_stores_r;
    assign stat_stall_cycles = stat_stall_r;
`endif

endmodule

// File: tb/tb_data_bus_initiator.sv
// Scoreboard bench for data_bus_initiator: directed requests, modelled bus responder, decoupled response monitor.
module tb_data_bus_initiator;
    import data_bus_initiator_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_store_data = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        misaligned;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic        bus_wait_req = 1'b0;
    logic [31:0] bus_read_data = 32'h0;
    logic        bus_valid = 1'b0;
`ifdef DATA_BUS_INITIATOR_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_stall_cycles;
`endif

    data_bus_initiator #(.MAX_PENDING(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .misaligned(misaligned),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_wait_req(bus_wait_req),
        .bus_read_data(bus_read_data), .bus_valid(bus_valid)
`ifdef DATA_BUS_INITIATOR_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 2;
    logic        stray = 1'b0;
    logic [31:0] exp_q[$];
    int          bvc_q[$];
    logic [31:0] rdq[$];
    int          due_q[$];
    logic [31:0] ddat_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus responder: accepts reads when not stalling, returns data in order after 'lat' cycles.
    initial begin
        logic acc;
        forever begin
            @(negedge clock);
            acc = bus_read_enable && !bus_wait_req && !reset;
            if (reset) begin
                due_q.delete();
                ddat_q.delete();
            end
            @(posedge clock);
            cyc++;
            if (acc) begin
                due_q.push_back(cyc + lat);
                ddat_q.push_back(rdq.size() > 0 ? rdq.pop_front() : 32'hDEAD_BEEF);
            end
            #1;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                bus_valid     = 1'b1;
                bus_read_data = ddat_q.pop_front();
                void'(due_q.pop_front());
                bvc_q.push_back(cyc);
            end else begin
                bus_valid     = stray;
                bus_read_data = 32'h5A5A_5A5A;
            end
        end
    end

    // Monitor: every response is checked against the scoreboard head and its bus_valid timing.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 data=0x%08h, expected no response", resp_data);
                end else begin
                    chk("resp_data", resp_data, exp_q.pop_front());
                    if (bvc_q.size() > 0) begin
                        chk("resp_latency_cycle", 32'(cyc), 32'(bvc_q.pop_front() + 1));
                    end else begin
                        chk("resp_without_bus_valid", 32'd1, 32'd0);
                    end
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic re_held);
        logic r;
        logic done;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = a; req_store_data = d;
        stalls = 0; re_held = 1'b1; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            r = req_ready;
            if (!r) begin
                stalls++;
                if (!bus_read_enable) re_held = 1'b0;
            end
            @(posedge clock);
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        #1 req_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata, input logic [31:0] expv,
                        output int stalls);
        logic held;
        rdq.push_back(rdata);
        exp_q.push_back(expv);
        issue(1'b0, f3, a, 32'h0, stalls, held);
    endtask

    task automatic store_chk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic [31:0] wd);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = f3; req_address = a; req_store_data = d;
        @(negedge clock);
        chk("st_byte_enable", 32'(bus_byte_enable), 32'(be));
        chk("st_write_data", bus_write_data, wd);
        chk("st_address", bus_address, {a[31:2], 2'b00});
        chk("st_ready_we_re_mis", {28'h0, req_ready, bus_write_enable, bus_read_enable, misaligned}, 32'h0000_000C);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic illegal_chk(input logic st, input logic [2:0] f3, input logic [31:0] a);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = a; req_store_data = 32'h1111_2222;
        @(negedge clock);
        chk("illegal_mis_ready_we_re", {28'h0, misaligned, req_ready, bus_write_enable, bus_read_enable}, 32'h0000_000C);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s;
        int   s_sum;
        logic held;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", resp_data, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Stores: lane steering and replication
        store_chk(F3_SB, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        store_chk(F3_SH, 32'h0000_1002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        store_chk(F3_SB, 32'h0000_2000, 32'hFFFF_FF3C, 4'b0001, 32'h3C3C_3C3C);
        store_chk(F3_SW, 32'h0000_1004, 32'h0123_4567, 4'b1111, 32'h0123_4567);

        // Illegal requests: misaligned or undefined funct3
        illegal_chk(1'b0, F3_LH, 32'h0000_1001);
        illegal_chk(1'b0, F3_LW, 32'h0000_1002);
        illegal_chk(1'b1, F3_SW, 32'h0000_1001);
        illegal_chk(1'b0, 3'b011, 32'h0000_1000);
        illegal_chk(1'b1, 3'b100, 32'h0000_1000);

        // Loads with extraction and extension
        lat = 2;
        load(F3_LB,  32'h0000_1002, 32'h0080_0000, 32'hFFFF_FF80, s);
        load(F3_LBU, 32'h0000_1002, 32'h0080_0000, 32'h0000_0080, s);
        load(F3_LH,  32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001, s);
        load(F3_LHU, 32'h0000_1002, 32'h8001_0000, 32'h0000_8001, s);
        load(F3_LH,  32'h0000_1000, 32'h1234_ABCD, 32'hFFFF_ABCD, s);
        load(F3_LB,  32'h0000_1000, 32'h0000_007F, 32'h0000_007F, s);
        load(F3_LBU, 32'h0000_1003, 32'hC100_0000, 32'h0000_00C1, s);
        load(F3_LW,  32'h0000_1004, 32'hDEAD_C0DE, 32'hDEAD_C0DE, s);
        drain();

        // bus_valid with nothing pending must be ignored
        @(negedge clock) stray = 1'b1;
        @(posedge clock);
        @(negedge clock) stray = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("stray_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1;

        // wait_req holds a load for three cycles
        bus_wait_req = 1'b1;
        fork
            begin
                repeat (3) @(posedge clock);
                #1 bus_wait_req = 1'b0;
            end
        join_none
        rdq.push_back(32'h7654_3210);
        exp_q.push_back(32'h7654_3210);
        issue(1'b0, F3_LW, 32'h0000_3000, 32'h0, s, held);
        chk("wait_req_stall_cycles", 32'(s), 32'd3);
        chk("wait_req_read_enable_held", 32'(held), 32'd1);
        drain();

        // Five back-to-back loads against a 4-deep tracker, bus latency 5
        lat = 5;
        s_sum = 0;
        for (int i = 0; i < 4; i++) begin
            load(F3_LW, 32'h0000_4000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'hA000_0000 + 32'(i), s);
            s_sum += s;
        end
        chk("b2b_first4_stalls", 32'(s_sum), 32'd0);
        load(F3_LW, 32'h0000_4010, 32'hA000_0004, 32'hA000_0004, s);
        chk("b2b_fifth_stalls", 32'(s), 32'd3);
        drain();

        // Reset with two loads outstanding
        load(F3_LB, 32'h0000_5001, 32'h0000_8000, 32'hFFFF_FF80, s);
        load(F3_LB, 32'h0000_5003, 32'h8000_0000, 32'hFFFF_FF80, s);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        bvc_q.delete();
        rdq.delete();
        @(negedge clock);
        chk("midreset_resp_valid", 32'(resp_valid), 32'd0);
        chk("midreset_resp_data", resp_data, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        lat = 2;
        repeat (2) @(posedge clock);
        #1;
        load(F3_LW, 32'h0000_6000, 32'hCAFE_F00D, 32'hCAFE_F00D, s);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
